fp_cvt_f2i_seq: RTL and testbench

//  Multi-cycle IEEE-754 single -> signed 32-bit integer converter (CVTF2I); decodes the float format the
//  ALU's CVTI2F path encodes. Sits beside the EX-stage ALU and replaces its combinational CVTF2I with a

---
 rtl/fp_cvt_f2i_seq.sv | 214 +++++++++++++++++++++
 tb/tb_fp_cvt_f2i_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fp_cvt_f2i_seq.sv
`default_nettype none
// ============================================================================
// Module      : fp_cvt_f2i_seq
// Description : Multi-cycle IEEE-754 single -> signed 32-bit integer
//               converter with valid/ready handshakes. Handles NaN/Inf,
//               saturation and inexact detection; the mantissa is aligned
//               by an iterative shifter moving up to SHIFT_STEP bits/cycle.
//               Optional feature macro: FP_CVT_ROUND_NEAREST_EN
//               (undefined: truncate toward zero; defined: round to
//               nearest even).
// Ports       : clk, reset_n (async, active-low), kill (sync abort),
//               in_valid/in_ready/a (operand), out_valid/out_ready,
//               result (signed integer), invalid, inexact (flags)
// Revision    : 1.0 - initial release
// ============================================================================
module fp_cvt_f2i_seq #(
    parameter int SHIFT_STEP = 1   // 1, 2, 4 or 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        kill,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        invalid,
    output logic        inexact
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [4:0] c_step = 5'(SHIFT_STEP);

    logic [1:0]  r_state;
    logic [31:0] r_mag;
    logic [4:0]  r_cnt;
    logic        r_left;
    logic        r_sign;
    logic        r_guard;
    logic        r_sticky;
    logic        r_special;
    logic        r_spec_inv;
    logic        r_spec_inx;
    logic        r_out_valid;
    logic [31:0] r_result;
    logic        r_invalid;
    logic        r_inexact;

    // ---------------------------------------------------------------- decode
    logic [7:0]  w_exp;
    logic        w_sign;
    logic        w_is_nan;
    logic        w_is_big;
    logic        w_is_min;
    logic        w_is_small;
    logic        w_left;
    logic [4:0]  w_cnt;

    assign w_exp    = a[30:23];
    assign w_sign   = a[31];
    assign w_is_nan = (w_exp == 8'hFF) && (a[22:0] != 23'd0);
    // exponent >= 31 cannot fit; also covers infinities
    assign w_is_big = (w_exp >= 8'd158);
    // -2^31 is the only in-range value with exponent 31
    assign w_is_min = (a == 32'hCF00_0000);
`ifdef FP_CVT_ROUND_NEAREST_EN
    // values in [0.5,1) may round up to 1, so they must go through the shifter
    assign w_is_small = (w_exp < 8'd126);
`else
    assign w_is_small = (w_exp < 8'd127);
`endif
    // binary point sits 23 bits above bit 0 of the mantissa: exponent 150
    assign w_left = (w_exp >= 8'd150);
    assign w_cnt  = w_left ? 5'(w_exp - 8'd150) : 5'(8'd150 - w_exp);

    // ----------------------------------------------------------- shift step
    logic [4:0]  w_k;
    logic [31:0] w_sh_mag;
    logic        w_sh_g;
    logic        w_sh_s;

    assign w_k = (r_cnt < c_step) ? r_cnt : c_step;

    // Unrolled single-bit shifts; only the first w_k stages are active.
    // On right shifts the previous guard bit folds into sticky.
    always_comb begin
        w_sh_mag = r_mag;
        w_sh_g   = r_guard;
        w_sh_s   = r_sticky;
        for (int i = 0; i < SHIFT_STEP; i++) begin
            if (5'(i) < w_k) begin
                if (r_left) begin
                    w_sh_mag = w_sh_mag << 1;
                end else begin
                    w_sh_s   = w_sh_s | w_sh_g;
                    w_sh_g   = w_sh_mag[0];
                    w_sh_mag = w_sh_mag >> 1;
                end
            end
        end
    end

    // --------------------------------------------------------------- finish
    logic [31:0] w_mag_rnd;
    logic [31:0] w_fin;

`ifdef FP_CVT_ROUND_NEAREST_EN
    // magnitude is below 2^24 whenever guard/sticky can be set: no overflow
    assign w_mag_rnd = r_mag + {31'd0, r_guard & (r_sticky | r_mag[0])};
`else
    assign w_mag_rnd = r_mag;
`endif
    assign w_fin = r_sign ? (~w_mag_rnd + 32'd1) : w_mag_rnd;

    // ------------------------------------------------------------ state/FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_mag       <= 32'd0;
            r_cnt       <= 5'd0;
            r_left      <= 1'b0;
            r_sign      <= 1'b0;
            r_guard     <= 1'b0;
            r_sticky    <= 1'b0;
            r_special   <= 1'b0;
            r_spec_inv  <= 1'b0;
            r_spec_inx  <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= 32'd0;
            r_invalid   <= 1'b0;
            r_inexact   <= 1'b0;
        end else if (kill) begin
            // abort: outputs keep their last committed values
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sign     <= w_sign;
                        r_left     <= w_left;
                        r_guard    <= 1'b0;
                        r_sticky   <= 1'b0;
                        r_spec_inv <= 1'b0;
                        r_spec_inx <= 1'b0;
                        r_state    <= S_SHIFT;
                        if (w_is_nan) begin
                            r_special  <= 1'b1;
                            r_mag      <= 32'h7FFF_FFFF;
                            r_spec_inv <= 1'b1;
                            r_cnt      <= 5'd0;
                        end else if (w_is_big) begin
                            r_special  <= 1'b1;
                            r_mag      <= (w_sign || w_is_min) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                            r_spec_inv <= !w_is_min;
                            r_cnt      <= 5'd0;
                        end else if (w_is_small) begin
                            r_special  <= 1'b1;
                            r_mag      <= 32'd0;
                            r_spec_inx <= (a[30:0] != 31'd0);
                            r_cnt      <= 5'd0;
                        end else begin
                            r_special  <= 1'b0;
                            r_mag      <= {8'd0, 1'b1, a[22:0]};
                            r_cnt      <= w_cnt;
                        end
                    end
                end
                S_SHIFT: begin
                    if (r_cnt == 5'd0) begin
                        r_state <= S_FINISH;
                    end else begin
                        r_mag    <= w_sh_mag;
                        r_guard  <= w_sh_g;
                        r_sticky <= w_sh_s;
                        r_cnt    <= r_cnt - w_k;
                    end
                end
                S_FINISH: begin
                    if (r_special) begin
                        r_result  <= r_mag;
                        r_invalid <= r_spec_inv;
                        r_inexact <= r_spec_inx;
                    end else begin
                        r_result  <= w_fin;
                        r_invalid <= 1'b0;
                        r_inexact <= r_guard | r_sticky;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                default: begin // S_DONE
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign invalid   = r_invalid;
    assign inexact   = r_inexact;

endmodule
`default_nettype wire

// File: tb/tb_fp_cvt_f2i_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_cvt_f2i_seq
// Description : Directed self-checking bench for fp_cvt_f2i_seq
//               (SHIFT_STEP = 1). Expected values are hand-computed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_cvt_f2i_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        kill;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        invalid;
    logic        inexact;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_cvt_f2i_seq #(.SHIFT_STEP(1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .kill      (kill),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .invalid   (invalid),
        .inexact   (inexact)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One full transaction: accept, latency, result/flags, optional hold, drain.
    task automatic do_op(input string tag, input logic [31:0] op, input logic [31:0] er,
                         input logic ev, input logic ex, input int lat, input int hold);
        int n;
        @(negedge clk);
        check({tag, "/ready_idle"}, {31'd0, in_ready}, 32'd1);
        a        = op;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check({tag, "/ready_busy"}, {31'd0, in_ready}, 32'd0);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            n++;
            #1;
        end
        check({tag, "/latency"}, n, lat);
        check({tag, "/result"}, result, er);
        check({tag, "/invalid"}, {31'd0, invalid}, {31'd0, ev});
        check({tag, "/inexact"}, {31'd0, inexact}, {31'd0, ex});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "/hold_result"}, result, er);
            check({tag, "/hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "/hold_ready"}, {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "/drain_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "/drain_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "/drain_result"}, result, er);
    endtask

    initial begin
        int seen;
        reset_n   = 1'b0;
        kill      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 32'd0;

        // reset state
        #12;
        check("rst/out_valid", {31'd0, out_valid}, 32'd0);
        check("rst/in_ready", {31'd0, in_ready}, 32'd1);
        check("rst/result", result, 32'd0);
        check("rst/invalid", {31'd0, invalid}, 32'd0);
        check("rst/inexact", {31'd0, inexact}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1.0: e=0, 23 right shifts
        do_op("one", 32'h3F80_0000, 32'd1, 1'b0, 1'b0, 25, 0);
`ifdef FP_CVT_ROUND_NEAREST_EN
        do_op("m2p75", 32'hC030_0000, 32'hFFFF_FFFD, 1'b0, 1'b1, 24, 0);
`else
        do_op("m2p75", 32'hC030_0000, 32'hFFFF_FFFE, 1'b0, 1'b1, 24, 0);
`endif
        // specials and saturation boundaries
        do_op("p2e31", 32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2, 0);
        do_op("m2e31", 32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 2, 0);
        do_op("m2e31p", 32'hCF00_0001, 32'h8000_0000, 1'b1, 1'b0, 2, 0);
        do_op("qnan", 32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2, 0);
        do_op("ninf", 32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 2, 0);
        // exact, no shift, with consumer back-pressure
        do_op("8388609", 32'h4B00_0001, 32'h0080_0001, 1'b0, 1'b0, 2, 5);
        // largest left shifts (7)
        do_op("maxpos", 32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 9, 0);
        do_op("maxneg", 32'hCEFF_FFFF, 32'h8000_0080, 1'b0, 1'b0, 9, 0);
        do_op("hundred", 32'h42C8_0000, 32'd100, 1'b0, 1'b0, 19, 0);
        // small values
`ifdef FP_CVT_ROUND_NEAREST_EN
        do_op("half", 32'h3F00_0000, 32'd0, 1'b0, 1'b1, 26, 0);
        do_op("onehalf", 32'h3FC0_0000, 32'd2, 1'b0, 1'b1, 25, 0);
`else
        do_op("half", 32'h3F00_0000, 32'd0, 1'b0, 1'b1, 2, 0);
        do_op("onehalf", 32'h3FC0_0000, 32'd1, 1'b0, 1'b1, 25, 0);
`endif
        do_op("denorm", 32'h0000_0001, 32'd0, 1'b0, 1'b1, 2, 0);
        do_op("negzero", 32'h8000_0000, 32'd0, 1'b0, 1'b0, 2, 0);
        do_op("hundred2", 32'h42C8_0000, 32'd100, 1'b0, 1'b0, 19, 0);

        // kill on the third SHIFT cycle
        @(negedge clk);
        a        = 32'h3F80_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        check("kill/in_ready", {31'd0, in_ready}, 32'd1);
        check("kill/out_valid", {31'd0, out_valid}, 32'd0);
        check("kill/result_kept", result, 32'd100);
        @(negedge clk);
        kill = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        check("kill/no_valid", seen, 32'd0);

        // async reset in the middle of SHIFT
        @(negedge clk);
        a        = 32'h3F80_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("arst/result", result, 32'd0);
        check("arst/out_valid", {31'd0, out_valid}, 32'd0);
        check("arst/in_ready", {31'd0, in_ready}, 32'd1);
        check("arst/invalid", {31'd0, invalid}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        do_op("after_rst", 32'h3F80_0000, 32'd1, 1'b0, 1'b0, 25, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
